// File: rtl/braille_cell_driver_if.sv
// Classifier-to-braille-cell link: letter strobe in, dot pattern and status out.
// The driver sits on the slave modport; the upstream/test side uses master.
interface braille_cell_driver_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_valid;
    logic [7:0]    i_alpha;
    logic [5:0]    o_dots;
    logic          o_dots_valid;
    logic [7:0]    o_char;
    logic          o_busy;
    logic [CW-1:0] o_fifo_count;
    logic          o_overflow;
    logic          o_reject;

    modport master (
        output i_valid,
        output i_alpha,
        input  o_dots,
        input  o_dots_valid,
        input  o_char,
        input  o_busy,
        input  o_fifo_count,
        input  o_overflow,
        input  o_reject
    );

    modport slave (
        input  i_valid,
        input  i_alpha,
        output o_dots,
        output o_dots_valid,
        output o_char,
        output o_busy,
        output o_fifo_count,
        output o_overflow,
        output o_reject
    );
endinterface

// File: rtl/braille_cell_driver.sv
// Buffers classified letters a-j and drives each as a 6-dot braille cell for a
// hold time followed by a blank gap. Optional macro: BRAILLE_REPEAT_FILTER_EN.
module braille_cell_driver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 10_000_000,
    parameter int CNT_BW      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    braille_cell_driver_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_BW-1:0] HOLD_LOAD  = CNT_BW'(HOLD_CYCLES - 1);
    localparam logic [CNT_BW-1:0] GAP_LOAD   = CNT_BW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [7:0]        head_code;

    logic [CNT_BW-1:0] timer;
    logic [CNT_BW-1:0] timer_nxt;
    logic [5:0]        dots_q;
    logic [5:0]        dots_nxt;
    logic              dots_valid_q;
    logic              dots_valid_nxt;
    logic [7:0]        char_q;
    logic [7:0]        char_nxt;
    logic              overflow_q;
    logic              reject_q;

    logic              supported;
    logic              is_repeat;
    logic              candidate;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;

    function automatic logic [5:0] map_dots(input logic [7:0] code);
        logic [5:0] pattern;
        case (code)
            8'h61:   pattern = 6'b000001;
            8'h62:   pattern = 6'b000011;
            8'h63:   pattern = 6'b001001;
            8'h64:   pattern = 6'b011001;
            8'h65:   pattern = 6'b010001;
            8'h66:   pattern = 6'b001011;
            8'h67:   pattern = 6'b011011;
            8'h68:   pattern = 6'b010011;
            8'h69:   pattern = 6'b001010;
            8'h6A:   pattern = 6'b011010;
            default: pattern = 6'b000000;
        endcase
        return pattern;
    endfunction

    assign supported  = (bus.i_alpha >= 8'h61) && (bus.i_alpha <= 8'h6A);
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign head_code  = fifo_mem[rd_ptr];

    // Pop only from IDLE with data already stored, so a fresh write never bypasses.
    assign pop       = (state == IDLE) && !fifo_empty;
    assign candidate = bus.i_valid && supported && !is_repeat;
    assign push      = candidate && (!fifo_full || pop);

`ifdef BRAILLE_REPEAT_FILTER_EN
    logic [7:0] last_code;

    assign is_repeat = (bus.i_alpha == last_code);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_code <= 8'h00;
        end else if (push) begin
            last_code <= bus.i_alpha;
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.i_alpha;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow_q <= candidate && fifo_full && !pop;
            reject_q   <= bus.i_valid && !supported;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            dots_q       <= '0;
            dots_valid_q <= 1'b0;
            char_q       <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            dots_q       <= dots_nxt;
            dots_valid_q <= dots_valid_nxt;
            char_q       <= char_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = SHOW;
            SHOW:    if (timer == '0) state_nxt = GAP;
            GAP:     if (timer == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The timer is loaded with N-1 so each phase lasts exactly N cycles.
    always_comb begin
        timer_nxt      = timer;
        dots_nxt       = dots_q;
        dots_valid_nxt = dots_valid_q;
        char_nxt       = char_q;
        case (state)
            IDLE: begin
                if (pop) begin
                    dots_nxt       = map_dots(head_code);
                    dots_valid_nxt = 1'b1;
                    char_nxt       = head_code;
                    timer_nxt      = HOLD_LOAD;
                end else begin
                    dots_nxt       = '0;
                    dots_valid_nxt = 1'b0;
                end
            end
            SHOW: begin
                if (timer == '0) begin
                    dots_nxt       = '0;
                    dots_valid_nxt = 1'b0;
                    timer_nxt      = GAP_LOAD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                dots_nxt       = '0;
                dots_valid_nxt = 1'b0;
                timer_nxt      = '0;
            end
        endcase
    end

    assign bus.o_dots       = dots_q;
    assign bus.o_dots_valid = dots_valid_q;
    assign bus.o_char       = char_q;
    assign bus.o_busy       = (state != IDLE) || !fifo_empty;
    assign bus.o_fifo_count = count;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_reject     = reject_q;
endmodule
